// File: rtl/rtc_set_ctrl_if.sv
// Bundle between the button/counter-chain side and the RTC time-set controller.
// master: buttons, tick and live time in; slave: the controller itself.
interface rtc_set_ctrl_if;
  logic       tick_1hz;
  logic       btn_mode;
  logic       btn_inc;
  logic [4:0] cur_hr;
  logic [5:0] cur_min;
  logic       rtc_en;
  logic       load;
  logic [4:0] load_hr;
  logic [5:0] load_min;
  logic [5:0] load_sec;
  logic       editing;
  logic [4:0] edit_hr;
  logic [5:0] edit_min;
  logic       blank_hr;
  logic       blank_min;

  modport master (
    output tick_1hz, btn_mode, btn_inc, cur_hr, cur_min,
    input  rtc_en, load, load_hr, load_min, load_sec,
    input  editing, edit_hr, edit_min, blank_hr, blank_min
  );

  modport slave (
    input  tick_1hz, btn_mode, btn_inc, cur_hr, cur_min,
    output rtc_en, load, load_hr, load_min, load_sec,
    output editing, edit_hr, edit_min, blank_hr, blank_min
  );
endinterface

// File: rtl/rtc_set_ctrl.sv
// Two-button time-set FSM: freezes the RTC, edits hours then minutes, and
// issues a one-cycle parallel load; an idle timeout discards the edit.
module rtc_set_ctrl #(
  parameter int unsigned TIMEOUT_TICKS = 30,
  parameter int unsigned TW            = 5
) (
  input logic          clk,
  input logic          rst,
  rtc_set_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    COMMIT  = 2'd3
  } state_t;

  localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT_TICKS - 1);

  state_t        state_q, state_d;
  logic          prev_mode_q, prev_inc_q;
  logic [4:0]    edit_hr_q, edit_hr_d;
  logic [5:0]    edit_min_q, edit_min_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          blink_q, blink_d;
  logic          load_q, load_d;
  logic [4:0]    load_hr_q, load_hr_d;
  logic [5:0]    load_min_q, load_min_d;

  logic ev_mode, ev_inc;
  logic next_is_edit;

  assign ev_mode = bus.btn_mode & ~prev_mode_q;
  assign ev_inc  = bus.btn_inc  & ~prev_inc_q;

  // Previous-button registers reset to 1 so a button held through reset gives no edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      prev_mode_q <= 1'b1;
      prev_inc_q  <= 1'b1;
      edit_hr_q   <= '0;
      edit_min_q  <= '0;
      cnt_q       <= '0;
      blink_q     <= 1'b0;
      load_q      <= 1'b0;
      load_hr_q   <= '0;
      load_min_q  <= '0;
    end else begin
      state_q     <= state_d;
      prev_mode_q <= bus.btn_mode;
      prev_inc_q  <= bus.btn_inc;
      edit_hr_q   <= edit_hr_d;
      edit_min_q  <= edit_min_d;
      cnt_q       <= cnt_d;
      blink_q     <= blink_d;
      load_q      <= load_d;
      load_hr_q   <= load_hr_d;
      load_min_q  <= load_min_d;
    end
  end

  // Priority in the edit states: MODE edge, then INC edge, then timeout tick.
  always_comb begin
    state_d    = state_q;
    edit_hr_d  = edit_hr_q;
    edit_min_d = edit_min_q;
    cnt_d      = cnt_q;
    case (state_q)
      RUN: begin
        cnt_d = '0;
        if (ev_mode) begin
          state_d    = SET_HR;
          edit_hr_d  = (bus.cur_hr  > 5'd23) ? '0 : bus.cur_hr;
          edit_min_d = (bus.cur_min > 6'd59) ? '0 : bus.cur_min;
        end
      end
      SET_HR: begin
        if (ev_mode) begin
          state_d = SET_MIN;
          cnt_d   = '0;
        end else if (ev_inc) begin
          edit_hr_d = (edit_hr_q == 5'd23) ? '0 : edit_hr_q + 5'd1;
          cnt_d     = '0;
        end else if (bus.tick_1hz) begin
          if (cnt_q == CNT_LAST) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      SET_MIN: begin
        if (ev_mode) begin
          state_d = COMMIT;
          cnt_d   = '0;
        end else if (ev_inc) begin
          edit_min_d = (edit_min_q == 6'd59) ? '0 : edit_min_q + 6'd1;
          cnt_d      = '0;
        end else if (bus.tick_1hz) begin
          if (cnt_q == CNT_LAST) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      COMMIT: begin
        state_d = RUN;
        cnt_d   = '0;
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // load is registered from the next state so it is high exactly while in COMMIT.
  always_comb begin
    next_is_edit = (state_d == SET_HR) || (state_d == SET_MIN);
    if (!next_is_edit || (state_d != state_q)) begin
      blink_d = 1'b0;
    end else if (bus.tick_1hz) begin
      blink_d = ~blink_q;
    end else begin
      blink_d = blink_q;
    end
    load_d     = (state_d == COMMIT);
    load_hr_d  = load_d ? edit_hr_d  : load_hr_q;
    load_min_d = load_d ? edit_min_d : load_min_q;
  end

  always_comb begin
    bus.rtc_en    = (state_q == RUN);
    bus.editing   = (state_q == SET_HR) || (state_q == SET_MIN);
    bus.blank_hr  = (state_q == SET_HR)  & blink_q;
    bus.blank_min = (state_q == SET_MIN) & blink_q;
    bus.load      = load_q;
    bus.load_hr   = load_hr_q;
    bus.load_min  = load_min_q;
    bus.load_sec  = '0;
    bus.edit_hr   = edit_hr_q;
    bus.edit_min  = edit_min_q;
  end

endmodule
